// File: rtl/present80_round_engine.sv
`default_nettype none
// ============================================================================
// Module   : present80_round_engine
// Brief    : Iterative PRESENT-80 encryption engine, one full round per clock.
// Revision : 1.0
// ============================================================================

module present80_sbox (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);
    always_comb begin
        o_nib = 4'h0;
        case (i_nib)
            4'h0: o_nib = 4'hC;
            4'h1: o_nib = 4'h5;
            4'h2: o_nib = 4'h6;
            4'h3: o_nib = 4'hB;
            4'h4: o_nib = 4'h9;
            4'h5: o_nib = 4'h0;
            4'h6: o_nib = 4'hA;
            4'h7: o_nib = 4'hD;
            4'h8: o_nib = 4'h3;
            4'h9: o_nib = 4'hE;
            4'hA: o_nib = 4'hF;
            4'hB: o_nib = 4'h8;
            4'hC: o_nib = 4'h4;
            4'hD: o_nib = 4'h7;
            4'hE: o_nib = 4'h1;
            4'hF: o_nib = 4'h2;
            default: o_nib = 4'h0;
        endcase
    end
endmodule

module present80_round_engine #(
    parameter int ROUNDS = 31
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] plaintext,
    input  logic [79:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] ciphertext,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [4:0] c_last_round = 5'(ROUNDS);

    state_t      r_fsm;
    state_t      w_fsm_nxt;
    logic [63:0] r_state;
    logic [79:0] r_key;
    logic [4:0]  r_round;
    logic [63:0] r_ct;

    logic [63:0] w_addkey;
    logic [63:0] w_sub;
    logic [63:0] w_perm;
    logic [79:0] w_key_rot;
    logic [3:0]  w_key_sb;
    logic [79:0] w_key_nxt;
    logic [63:0] w_ct_nxt;
    logic        w_last;
    logic        w_accept;
    logic        w_run;

    // Round datapath: key addition, sBoxLayer, pLayer
    assign w_addkey = r_state ^ r_key[79:16];

    for (genvar j = 0; j < 16; j++) begin : g_sbox
        present80_sbox u_sbox (
            .i_nib (w_addkey[4*j +: 4]),
            .o_nib (w_sub[4*j +: 4])
        );
    end

    for (genvar i = 0; i < 63; i++) begin : g_perm
        assign w_perm[(16*i) % 63] = w_sub[i];
    end
    assign w_perm[63] = w_sub[63];

    // Key schedule: rotate left 61, S-box on top nibble, counter into [19:15]
    assign w_key_rot = {r_key[18:0], r_key[79:19]};

    present80_sbox u_key_sbox (
        .i_nib (w_key_rot[79:76]),
        .o_nib (w_key_sb)
    );

    assign w_key_nxt = {w_key_sb, w_key_rot[75:20], w_key_rot[19:15] ^ r_round, w_key_rot[14:0]};
    assign w_ct_nxt  = w_perm ^ w_key_nxt[79:16];
    assign w_last    = (r_round == c_last_round);
    assign w_accept  = in_valid & in_ready;
    assign w_run     = (r_fsm == S_RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_fsm_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_fsm_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_fsm_nxt = S_IDLE;
                end
            end
            default: begin
                w_fsm_nxt = S_IDLE;
            end
        endcase
    end

    // The counter holds on the final round so it never wraps past 31
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= 64'h0;
            r_key   <= 80'h0;
            r_round <= 5'd1;
            r_ct    <= 64'h0;
        end else if (w_accept) begin
            r_state <= plaintext;
            r_key   <= key;
            r_round <= 5'd1;
        end else if (w_run) begin
            r_state <= w_perm;
            r_key   <= w_key_nxt;
            if (w_last) begin
                r_ct <= w_ct_nxt;
            end else begin
                r_round <= r_round + 5'd1;
            end
        end
    end

    assign ciphertext = r_ct;

endmodule
`default_nettype wire
